// File: rtl/funct_gen_ctrl.sv
// funct_gen_ctrl: control FSM and address sequencer for the function generator.
// IDLE / CONFI / GEN state machine driven by the host strobes, a saturating
// write-address counter for loading the sample RAM in CONFI, and a read-address
// sequencer with a programmable sample-rate divider for playback in GEN.
// Optional feature macro: FGEN_ONESHOT_EN adds oneshot_i / done_o. With it
// defined, a waveform can be played exactly once per GEN visit.
module funct_gen_ctrl #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int DIVW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_low_i,
    input  logic            enh_conf_i,
    input  logic            wr_valid_i,
    input  logic [AW-1:0]   len_i,
    input  logic [DIVW-1:0] div_i,
`ifdef FGEN_ONESHOT_EN
    input  logic            oneshot_i,
    output logic            done_o,
`endif
    output logic [1:0]      state_o,
    output logic            enh_config_fsm,
    output logic            enh_gen_fsm,
    output logic            clrh_addr_fsm,
    output logic            wr_en_o,
    output logic [AW-1:0]   wr_addr_o,
    output logic            cfg_full_o,
    output logic            rd_en_o,
    output logic [AW-1:0]   rd_addr_o,
    output logic            wrap_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONFI = 2'd1,
        ST_GEN   = 2'd2
    } state_e;

    localparam logic [AW-1:0]   ADDR_MAX = AW'(DEPTH - 1);
    localparam logic [AW-1:0]   ADDR_ONE = AW'(1);
    localparam logic [DIVW-1:0] DIV_ONE  = DIVW'(1);

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic              cfg_full_q, cfg_full_d;
    logic [AW-1:0]     len_q, len_d;
    logic [DIVW-1:0]   div_q, div_d;
    logic [DIVW-1:0]   div_cnt_q, div_cnt_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;

    logic              in_confi;
    logic              in_gen;
    logic              confi_entry;
    logic              gen_entry;
    logic              gen_exit;
    logic              strobe;
    logic              at_len;
    logic              stop_at_wrap;
    logic              playback_done;
    logic [AW-1:0]     len_clamped;

    // Next state: configuration request wins, then generation enable, else idle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d = ST_IDLE;
        if (enh_conf_i) begin
            state_d = ST_CONFI;
        end else if (!en_low_i) begin
            state_d = ST_GEN;
        end
    end

    assign in_confi    = (state_q == ST_CONFI);
    assign in_gen      = (state_q == ST_GEN);
    assign confi_entry = (state_d == ST_CONFI) && !in_confi;
    assign gen_entry   = (state_d == ST_GEN) && !in_gen;
    assign gen_exit    = in_gen && (state_d != ST_GEN);

    // Status outputs decode the registered state, so they trail the inputs by one cycle.
    assign state_o        = state_q;
    assign enh_config_fsm = in_confi;
    assign enh_gen_fsm    = in_gen;
    assign clrh_addr_fsm  = (state_q == ST_IDLE) || (state_q == ST_CONFI);

    // A write is taken only inside CONFI and only until the last RAM slot has been filled.
    assign wr_en_o    = wr_valid_i & in_confi & ~cfg_full_q;
    assign wr_addr_o  = wr_addr_q;
    assign cfg_full_o = cfg_full_q;

    // Write-address counter: cleared on CONFI entry, saturates at the top slot.
    always_comb begin
        wr_addr_d  = wr_addr_q;
        cfg_full_d = cfg_full_q;
        if (confi_entry) begin
            wr_addr_d  = '0;
            cfg_full_d = 1'b0;
        end else if (wr_en_o) begin
            if (wr_addr_q == ADDR_MAX) begin
                cfg_full_d = 1'b1;
            end else begin
                wr_addr_d = wr_addr_q + ADDR_ONE;
            end
        end
    end

    // Length is clamped so playback can never address beyond the RAM.
    assign len_clamped = (32'(len_i) > 32'(DEPTH - 1)) ? ADDR_MAX : len_i;

    // Sample strobe fires when the divider reaches the latched period, unless a
    // one-shot playback has already completed.
    assign strobe    = in_gen && !playback_done && (div_cnt_q == div_q);
    assign at_len    = (rd_addr_q == len_q);
    assign rd_en_o   = strobe;
    assign wrap_o    = strobe && at_len;
    assign rd_addr_o = rd_addr_q;

    // Read sequencer: latch settings on GEN entry, step the divider and address in GEN,
    // and clear the playback position whenever GEN is left.
    always_comb begin
        len_d     = len_q;
        div_d     = div_q;
        div_cnt_d = div_cnt_q;
        rd_addr_d = rd_addr_q;
        if (gen_entry) begin
            len_d     = len_clamped;
            div_d     = div_i;
            div_cnt_d = '0;
            rd_addr_d = '0;
        end else if (gen_exit) begin
            div_cnt_d = '0;
            rd_addr_d = '0;
        end else if (in_gen && !playback_done) begin
            if (strobe) begin
                div_cnt_d = '0;
                if (at_len) begin
                    // A one-shot run parks on the last sample instead of wrapping.
                    rd_addr_d = stop_at_wrap ? rd_addr_q : '0;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_ONE;
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_ONE;
            end
        end
    end

`ifdef FGEN_ONESHOT_EN
    logic oneshot_q, oneshot_d;
    logic done_q, done_d;

    // One-shot control: mode latched on GEN entry, done set by the wrap strobe,
    // cleared whenever GEN is entered or left.
    always_comb begin
        oneshot_d = oneshot_q;
        done_d    = done_q;
        if (gen_entry) begin
            oneshot_d = oneshot_i;
            done_d    = 1'b0;
        end else if (gen_exit) begin
            done_d = 1'b0;
        end else if (wrap_o && oneshot_q) begin
            done_d = 1'b1;
        end
    end

    // One-shot state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oneshot_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            oneshot_q <= oneshot_d;
            done_q    <= done_d;
        end
    end

    assign stop_at_wrap  = oneshot_q;
    assign playback_done = done_q;
    assign done_o        = done_q;
`else
    assign stop_at_wrap  = 1'b0;
    assign playback_done = 1'b0;
`endif

    // State, counters and latched playback settings.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            state_q    <= ST_IDLE;
            wr_addr_q  <= '0;
            cfg_full_q <= 1'b0;
            len_q      <= '0;
            div_q      <= '0;
            div_cnt_q  <= '0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            cfg_full_q <= cfg_full_d;
            len_q      <= len_d;
            div_q      <= div_d;
            div_cnt_q  <= div_cnt_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

endmodule
